// File: rtl/alu_wb_stage_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : wb_pkg
// Brief  : Shared widths, entry layout and occupancy encoding for the
//          ALU writeback stage.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
package wb_pkg;

  localparam int DW = 8;
  localparam int AW = 3;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    WB_EMPTY = 2'd0,
    WB_ONE   = 2'd1,
    WB_FULL  = 2'd2
  } wb_occ_t;

endpackage
`default_nettype wire

// File: rtl/alu_wb_stage_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : alu_wb_stage_if
// Brief  : Bundle of ALU-side, flag, register-file and forwarding signals
//          of the writeback stage. master = surroundings, slave = stage.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
interface alu_wb_stage_if;
  import wb_pkg::*;

  logic          ex_valid;
  logic          ex_ready;
  logic [DW-1:0] rslt;
  logic [AW-1:0] rd_addr;
  logic          rd_we;
  logic          sc_o;
  logic          sc_en;
  logic          sc_clr;
  logic          pari;
  logic          pari_en;
  logic          pari_clr;
  logic          sc_q;
  logic          pari_q;
  logic          wb_stall;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [AW-1:0] rs_addr;
  logic          rs_pend;
  logic [DW-1:0] rs_data;

  modport master (
    output ex_valid, rslt, rd_addr, rd_we, sc_o, sc_en, sc_clr,
           pari, pari_en, pari_clr, wb_stall, rs_addr,
    input  ex_ready, sc_q, pari_q, rf_we, rf_waddr, rf_wdata,
           rs_pend, rs_data
  );

  modport slave (
    input  ex_valid, rslt, rd_addr, rd_we, sc_o, sc_en, sc_clr,
           pari, pari_en, pari_clr, wb_stall, rs_addr,
    output ex_ready, sc_q, pari_q, rf_we, rf_waddr, rf_wdata,
           rs_pend, rs_data
  );

endinterface
`default_nettype wire

// File: rtl/alu_wb_stage_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : wb_skid_fifo2
// Brief  : Two-entry FIFO of writeback entries. Exposes both slots with
//          valid bits and the index of the youngest slot for forwarding.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module wb_skid_fifo2
  import wb_pkg::*;
(
  input  wire logic            clk,
  input  wire logic            reset,
  input  wire logic            push_i,
  input  wire wb_entry_t       entry_i,
  input  wire logic            pop_i,
  output logic                 full_o,
  output logic                 empty_o,
  output wb_entry_t            head_o,
  output wb_entry_t [1:0]      ent_o,
  output logic      [1:0]      vld_o,
  output logic                 tail_o
);

  wb_occ_t         occ_q, occ_d;
  logic            rd_ptr_q, wr_ptr_q;
  logic      [1:0] vld_q, vld_d;
  wb_entry_t [1:0] mem_q;

  // Occupancy state register
  always_ff @(posedge clk) begin
    if (reset) occ_q <= WB_EMPTY;
    else       occ_q <= occ_d;
  end

  // Occupancy next state and per-slot valid bits; pop is applied before push
  // so a simultaneous pop/push at one entry leaves the new entry valid.
  always_comb begin
    occ_d = occ_q;
    vld_d = vld_q;
    if (pop_i)  vld_d[rd_ptr_q] = 1'b0;
    if (push_i) vld_d[wr_ptr_q] = 1'b1;
    unique case ({push_i, pop_i})
      2'b10:   occ_d = (occ_q == WB_EMPTY) ? WB_ONE : WB_FULL;
      2'b01:   occ_d = (occ_q == WB_FULL)  ? WB_ONE : WB_EMPTY;
      default: occ_d = occ_q;
    endcase
  end

  // Pointer and valid registers; reset discards every buffered entry
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      vld_q    <= 2'b00;
    end else begin
      if (pop_i)  rd_ptr_q <= ~rd_ptr_q;
      if (push_i) wr_ptr_q <= ~wr_ptr_q;
      vld_q <= vld_d;
    end
  end

  // Entry storage; contents are only meaningful under the valid bits
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= entry_i;
  end

  assign full_o  = (occ_q == WB_FULL);
  assign empty_o = (occ_q == WB_EMPTY);
  assign head_o  = mem_q[rd_ptr_q];
  assign ent_o   = mem_q;
  assign vld_o   = vld_q;
  // The most recently written slot is the one just behind the write pointer.
  assign tail_o  = ~wr_ptr_q;

endmodule
`default_nettype wire

// File: rtl/alu_wb_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : alu_wb_stage
// Brief  : Execute->writeback stage: SC/PARI flag registers, 2-entry skid
//          buffer draining to the register-file port, forwarding lookup.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module alu_wb_stage
  import wb_pkg::*;
(
  input  wire logic     clk,
  input  wire logic     reset,
  alu_wb_stage_if.slave wb
);

  logic            acc, push, pop;
  logic            full, empty, tail;
  wb_entry_t       head, new_entry;
  wb_entry_t [1:0] ent;
  logic      [1:0] vld;
  logic            sc_flag_q, sc_flag_d;
  logic            pari_flag_q, pari_flag_d;
  logic            fwd_pend;
  logic [DW-1:0]   fwd_data;

  // ex_ready comes from registered occupancy only, so a full buffer refuses
  // input even in a cycle where it drains.
  assign wb.ex_ready = ~full;
  assign acc         = wb.ex_valid & ~full;
  assign push        = acc & wb.rd_we;
  assign pop         = ~empty & ~wb.wb_stall;

  assign new_entry.addr = wb.rd_addr;
  assign new_entry.data = wb.rslt;

  wb_skid_fifo2 u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .entry_i (new_entry),
    .pop_i   (pop),
    .full_o  (full),
    .empty_o (empty),
    .head_o  (head),
    .ent_o   (ent),
    .vld_o   (vld),
    .tail_o  (tail)
  );

  assign wb.rf_we    = pop;
  assign wb.rf_waddr = empty ? '0 : head.addr;
  assign wb.rf_wdata = empty ? '0 : head.data;

  // Flag next state: only accepted ops touch the flags, clear beats load
  always_comb begin
    sc_flag_d   = sc_flag_q;
    pari_flag_d = pari_flag_q;
    if (acc) begin
      if (wb.sc_clr)        sc_flag_d = 1'b0;
      else if (wb.sc_en)    sc_flag_d = wb.sc_o;
      if (wb.pari_clr)      pari_flag_d = 1'b0;
      else if (wb.pari_en)  pari_flag_d = wb.pari;
    end
  end

  // Flag registers
  always_ff @(posedge clk) begin
    if (reset) begin
      sc_flag_q   <= 1'b0;
      pari_flag_q <= 1'b0;
    end else begin
      sc_flag_q   <= sc_flag_d;
      pari_flag_q <= pari_flag_d;
    end
  end

  assign wb.sc_q   = sc_flag_q;
  assign wb.pari_q = pari_flag_q;

  // Forwarding lookup: older slot first, youngest overrides on double match
  always_comb begin
    fwd_pend = 1'b0;
    fwd_data = '0;
    if (vld[~tail] && (ent[~tail].addr == wb.rs_addr)) begin
      fwd_pend = 1'b1;
      fwd_data = ent[~tail].data;
    end
    if (vld[tail] && (ent[tail].addr == wb.rs_addr)) begin
      fwd_pend = 1'b1;
      fwd_data = ent[tail].data;
    end
  end

  assign wb.rs_pend = fwd_pend;
  assign wb.rs_data = fwd_data;

endmodule
`default_nettype wire

// File: tb/tb_alu_wb_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : tb_alu_wb_stage
// Brief  : Directed-vector bench with a queue-based reference model.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module tb_alu_wb_stage;

  logic clk;
  logic reset;

  alu_wb_stage_if ifc ();

  alu_wb_stage dut (
    .clk   (clk),
    .reset (reset),
    .wb    (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         rst, v, we;
    logic [2:0] rd;
    logic [7:0] d;
    bit         sco, sce, scc, pa, pae, pac, st;
    logic [2:0] rs;
    bit         chk, erdy, ewe;
    logic [2:0] ewa;
    logic [7:0] ewd;
    bit         esc, epa, epend;
    logic [7:0] ers;
  } row_t;

  row_t rows[$];
  int   cur;
  bit   running;
  int   n_tests;
  int   n_fail;

  function automatic row_t in_(bit rst, bit v, bit we, logic [2:0] rd, logic [7:0] d,
                               bit sco, bit sce, bit scc, bit pa, bit pae, bit pac,
                               bit st, logic [2:0] rs);
    row_t r;
    r.rst = rst; r.v = v; r.we = we; r.rd = rd; r.d = d;
    r.sco = sco; r.sce = sce; r.scc = scc; r.pa = pa; r.pae = pae; r.pac = pac;
    r.st = st; r.rs = rs;
    r.chk = 0; r.erdy = 0; r.ewe = 0; r.ewa = 0; r.ewd = 0;
    r.esc = 0; r.epa = 0; r.epend = 0; r.ers = 0;
    return r;
  endfunction

  function automatic row_t ex_(row_t r, bit rdy, bit we, logic [2:0] wa, logic [7:0] wd,
                               bit sc, bit pa, bit pend, logic [7:0] rsd);
    row_t o = r;
    o.chk = 1; o.erdy = rdy; o.ewe = we; o.ewa = wa; o.ewd = wd;
    o.esc = sc; o.epa = pa; o.epend = pend; o.ers = rsd;
    return o;
  endfunction

  task automatic apply(input row_t r);
    reset        = r.rst;
    ifc.ex_valid = r.v;
    ifc.rd_we    = r.we;
    ifc.rd_addr  = r.rd;
    ifc.rslt     = r.d;
    ifc.sc_o     = r.sco;
    ifc.sc_en    = r.sce;
    ifc.sc_clr   = r.scc;
    ifc.pari     = r.pa;
    ifc.pari_en  = r.pae;
    ifc.pari_clr = r.pac;
    ifc.wb_stall = r.st;
    ifc.rs_addr  = r.rs;
  endtask

  // Reference model: buffered writes as a plain queue, flags as two bits.
  logic [10:0] mq[$];
  bit          msc, mpa;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %0h expected %0h", name, cur, act, exp);
    end
  endtask

  // Compare DUT against model (and literal row expectations), then advance model.
  always @(negedge clk) begin
    if (running) begin
      bit         e_rdy, e_we, e_pend, acc, pop;
      logic [2:0] e_wa;
      logic [7:0] e_wd, e_rsd;
      row_t       r;
      r      = rows[cur];
      e_rdy  = (mq.size() < 2);
      e_we   = (mq.size() != 0) && !ifc.wb_stall;
      e_wa   = (mq.size() != 0) ? mq[0][10:8] : 3'd0;
      e_wd   = (mq.size() != 0) ? mq[0][7:0]  : 8'd0;
      e_pend = 0;
      e_rsd  = 0;
      foreach (mq[k]) begin
        if (mq[k][10:8] == ifc.rs_addr) begin
          e_pend = 1;
          e_rsd  = mq[k][7:0];
        end
      end
      if (cur > 0) begin
        check("m_ready",  {31'd0, ifc.ex_ready}, {31'd0, e_rdy});
        check("m_rf_we",  {31'd0, ifc.rf_we},    {31'd0, e_we});
        check("m_waddr",  {29'd0, ifc.rf_waddr}, {29'd0, e_wa});
        check("m_wdata",  {24'd0, ifc.rf_wdata}, {24'd0, e_wd});
        check("m_sc",     {31'd0, ifc.sc_q},     {31'd0, msc});
        check("m_pari",   {31'd0, ifc.pari_q},   {31'd0, mpa});
        check("m_pend",   {31'd0, ifc.rs_pend},  {31'd0, e_pend});
        check("m_rsdata", {24'd0, ifc.rs_data},  {24'd0, e_rsd});
      end
      if (r.chk) begin
        check("l_ready",  {31'd0, ifc.ex_ready}, {31'd0, r.erdy});
        check("l_rf_we",  {31'd0, ifc.rf_we},    {31'd0, r.ewe});
        check("l_waddr",  {29'd0, ifc.rf_waddr}, {29'd0, r.ewa});
        check("l_wdata",  {24'd0, ifc.rf_wdata}, {24'd0, r.ewd});
        check("l_sc",     {31'd0, ifc.sc_q},     {31'd0, r.esc});
        check("l_pari",   {31'd0, ifc.pari_q},   {31'd0, r.epa});
        check("l_pend",   {31'd0, ifc.rs_pend},  {31'd0, r.epend});
        check("l_rsdata", {24'd0, ifc.rs_data},  {24'd0, r.ers});
      end
      if (reset) begin
        mq.delete();
        msc = 0;
        mpa = 0;
      end else begin
        acc = ifc.ex_valid && (mq.size() < 2);
        pop = e_we;
        if (pop) void'(mq.pop_front());
        if (acc && ifc.rd_we) mq.push_back({ifc.rd_addr, ifc.rslt});
        if (acc) begin
          if (ifc.sc_clr)        msc = 0;
          else if (ifc.sc_en)    msc = ifc.sc_o;
          if (ifc.pari_clr)      mpa = 0;
          else if (ifc.pari_en)  mpa = ifc.pari;
        end
      end
    end
  end

  initial begin
    row_t idle;
    idle = in_(0,0,0,0,8'h00,0,0,0,0,0,0,0,0);
    // reset, then idle with reset-state outputs
    rows.push_back(in_(1,0,0,0,8'h00,0,0,0,0,0,0,0,0));
    for (int i = 0; i < 5; i++) rows.push_back(ex_(idle,1,0,0,8'h00,0,0,0,8'h00));
    // single write with SC load; popped entry still forwards
    rows.push_back(ex_(in_(0,1,1,3,8'hA5,1,1,0,0,0,0,0,0),1,0,0,8'h00,0,0,0,8'h00));
    rows.push_back(ex_(in_(0,0,0,0,8'h00,0,0,0,0,0,0,0,3),1,1,3,8'hA5,1,0,1,8'hA5));
    rows.push_back(ex_(in_(0,0,0,0,8'h00,0,0,0,0,0,0,0,3),1,0,0,8'h00,1,0,0,8'h00));
    // fill under stall, third op held, then drain in order
    rows.push_back(ex_(in_(0,1,1,1,8'h11,0,0,0,0,0,0,1,0),1,0,0,8'h00,1,0,0,8'h00));
    rows.push_back(ex_(in_(0,1,1,2,8'h22,0,0,0,0,0,0,1,0),1,0,1,8'h11,1,0,0,8'h00));
    rows.push_back(ex_(in_(0,1,1,5,8'h55,0,0,0,0,0,0,1,0),0,0,1,8'h11,1,0,0,8'h00));
    rows.push_back(ex_(in_(0,1,1,5,8'h55,0,0,0,0,0,0,1,0),0,0,1,8'h11,1,0,0,8'h00));
    rows.push_back(ex_(in_(0,1,1,5,8'h55,0,0,0,0,0,0,0,0),0,1,1,8'h11,1,0,0,8'h00));
    rows.push_back(ex_(in_(0,1,1,5,8'h55,0,0,0,0,0,0,0,0),1,1,2,8'h22,1,0,0,8'h00));
    rows.push_back(ex_(idle,1,1,5,8'h55,1,0,0,8'h00));
    rows.push_back(ex_(idle,1,0,0,8'h00,1,0,0,8'h00));
    // flags-only ops: PARI load, then SC clear beating load
    rows.push_back(ex_(in_(0,1,0,0,8'h00,0,0,0,1,1,0,0,0),1,0,0,8'h00,1,0,0,8'h00));
    rows.push_back(ex_(in_(0,1,0,0,8'h00,1,1,1,0,0,0,0,0),1,0,0,8'h00,1,1,0,8'h00));
    rows.push_back(ex_(idle,1,0,0,8'h00,0,1,0,8'h00));
    // double match on r4: youngest wins; miss returns zero
    rows.push_back(ex_(in_(0,1,1,4,8'h10,0,0,0,0,0,0,1,0),1,0,0,8'h00,0,1,0,8'h00));
    rows.push_back(ex_(in_(0,1,1,4,8'h20,0,0,0,0,0,0,1,4),1,0,4,8'h10,0,1,1,8'h10));
    rows.push_back(ex_(in_(0,0,0,0,8'h00,0,0,0,0,0,0,1,4),0,0,4,8'h10,0,1,1,8'h20));
    rows.push_back(ex_(in_(0,0,0,0,8'h00,0,0,0,0,0,0,1,6),0,0,4,8'h10,0,1,0,8'h00));
    rows.push_back(ex_(idle,0,1,4,8'h10,0,1,0,8'h00));
    rows.push_back(ex_(idle,1,1,4,8'h20,0,1,0,8'h00));
    // set SC, buffer two entries, reset mid-operation
    rows.push_back(ex_(in_(0,1,0,0,8'h00,1,1,0,0,0,0,1,0),1,0,0,8'h00,0,1,0,8'h00));
    rows.push_back(ex_(in_(0,1,1,7,8'h77,0,0,0,0,0,0,1,0),1,0,0,8'h00,1,1,0,8'h00));
    rows.push_back(ex_(in_(0,1,1,6,8'h66,0,0,0,0,0,0,1,0),1,0,7,8'h77,1,1,0,8'h00));
    rows.push_back(ex_(in_(0,0,0,0,8'h00,0,0,0,0,0,0,1,7),0,0,7,8'h77,1,1,1,8'h77));
    rows.push_back(ex_(in_(1,0,0,0,8'h00,0,0,0,0,0,0,1,7),0,0,7,8'h77,1,1,1,8'h77));
    for (int i = 0; i < 3; i++)
      rows.push_back(ex_(in_(0,0,0,0,8'h00,0,0,0,0,0,0,0,7),1,0,0,8'h00,0,0,0,8'h00));

    n_tests = 0;
    n_fail  = 0;
    msc     = 0;
    mpa     = 0;
    cur     = 0;
    apply(rows[0]);
    running = 1;
    for (int i = 1; i < rows.size(); i++) begin
      @(posedge clk);
      #1;
      cur = i;
      apply(rows[i]);
    end
    @(negedge clk);
    #1;
    running = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
